mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 op  in  3  opcode, instr[15:13]: 000 R-type, 001 lw, 010 sw, 011 beq, 100 addi, 101 j, 110/111 illegal.
REQ-004 funct  in  4  R-type function, instr[3:0]: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, others illegal.
REQ-005 zero  in  1  ALU zero flag from datapath.
REQ-006 imem_ready / dmem_ready  in  1 each  instruction- and data-memory access complete this cycle.
REQ-007 pcen  out  1  PC load enable, = pcwrite OR (branch AND zero).
REQ-008 irwrite, regwrite, memwrite, dmem_read  out  1 each  IR load, register-file write, data-memory write, data-memory read strobes.
REQ-009 alusrca  out  1  0 = PC, 1 = register A.
REQ-010 alusrcb  out  2  00 = register B, 01 = PC-increment constant, 10 = sign-extended imm, 11 = sign-extended imm shifted.
REQ-011 pcsrc  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012 regdst, memtoreg  out  1 each  1 = rd dest, 1 = write-back from memory.
REQ-013 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-014 illegal  out  1  one-cycle pulse on undecodable instruction.
REQ-015 state  out  4  current FSM state, for debug.

Function
REQ-016 Moore FSM; every output except pcen is a function of state plus the ready inputs only; unlisted outputs are 0 and alucontrol defaults to add.
REQ-017 FETCH: alusrca=0, alusrcb=01, pcsrc=00; irwrite=pcwrite=imem_ready; hold until imem_ready=1, then DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut); next by op: lw/sw->MEMADR, R legal->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP.
REQ-019 DECODE with illegal op or illegal R funct: illegal=1 for that cycle, next FETCH, no register or memory write.
REQ-020 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR.
REQ-021 MEMRD: dmem_read=1 held until dmem_ready=1, then MEMWB; MEMWB: regwrite=1, memtoreg=1, regdst=0, then FETCH.
REQ-022 MEMWR: memwrite=1 held stable every cycle until dmem_ready=1, then FETCH; exactly one write acknowledged.
REQ-023 EXEC: alusrca=1, alusrcb=00, alucontrol from funct; then ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
REQ-024 BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01; then FETCH.
REQ-025 ADDIEX: alusrca=1, alusrcb=10, add; then ADDIWB: regwrite=1, regdst=0, then FETCH.
REQ-026 JUMP: pcwrite=1, pcsrc=10; then FETCH.
REQ-027 Latency with ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; each memory wait cycle adds 1.
REQ-028 Ready inputs ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-029 reset=1 at any edge, including mid-wait in MEMRD/MEMWR, forces FETCH next cycle; reset dominates all transitions.
REQ-030 While reset is asserted and in the cycle after: pcen, irwrite, regwrite, memwrite, dmem_read, illegal = 0.

Structure
REQ-031 Package mc_pkg holds the state enum, opcode and funct constants, and the alucontrol/alusrcb/pcsrc encodings.
REQ-032 Sub-module mc_aludec maps (state class, funct) to alucontrol combinationally; the FSM lives in mc_controller.

Verification
REQ-033 Reset, then R add (op 000, funct 0000) with imem_ready=1: FETCH, DECODE, EXEC, ALUWB; alucontrol=010 in EXEC; regwrite=1, regdst=1 in cycle 4 only.
REQ-034 lw with dmem_ready low for 3 cycles: MEMRD held 4 cycles with dmem_read=1; regwrite/memtoreg=1 in the single MEMWB cycle.
REQ-035 beq with zero=1 -> pcen=1 in BRANCH; with zero=0 -> pcen=0 in BRANCH.
REQ-036 sw, reset asserted during the 2nd MEMWR wait cycle -> memwrite=0 next cycle, state=FETCH.
REQ-037 op=110, then R with funct=1111 -> illegal=1 for one DECODE cycle each; no regwrite/memwrite; back to FETCH.
REQ-038 FETCH with imem_ready=0 for 2 cycles -> irwrite=pcwrite=0 during the wait; both 1 in the ready cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// instruction fields and datapath select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // How the ALU operation is chosen in a given state.
    typedef enum logic [1:0] {
        AC_ADD   = 2'd0,
        AC_SUB   = 2'd1,
        AC_FUNCT = 2'd2
    } alu_class_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;

    localparam logic [3:0] F_ADD = 4'b0000;
    localparam logic [3:0] F_SUB = 4'b0001;
    localparam logic [3:0] F_AND = 4'b0010;
    localparam logic [3:0] F_OR  = 4'b0011;
    localparam logic [3:0] F_SLT = 4'b0100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_INC   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic instr_illegal(input logic [2:0] op, input logic [3:0] funct);
        return (op > OP_J) || ((op == OP_RTYPE) && (funct > F_SLT));
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decoder: fixed add/sub for address and branch states,
// R-type function field otherwise.
module mc_aludec
    import mc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [3:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        alucontrol = ALU_ADD;
        case (alu_class)
            AC_SUB: alucontrol = ALU_SUB;
            AC_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM. Outputs decode from the current state (plus the
// ready inputs in wait states); all write strobes are silenced during reset and the cycle after.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [3:0]  funct,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pcen,
    output logic        irwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        dmem_read,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        regdst,
    output logic        memtoreg,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q;
    logic       reset_q;
    logic       quiet;
    logic       pcwrite, branch;
    logic       irwrite_raw, regwrite_raw, memwrite_raw, dmem_read_raw, illegal_raw;
    alu_class_t alu_class;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        reset_q <= reset;
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                // The cycle after reset holds in FETCH with strobes off, so no fetch is consumed.
                S_FETCH:  if (imem_ready && !reset_q) state_q <= S_DECODE;
                S_DECODE: begin
                    if (instr_illegal(op, funct)) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (op)
                            OP_LW, OP_SW: state_q <= S_MEMADR;
                            OP_RTYPE:     state_q <= S_EXEC;
                            OP_BEQ:       state_q <= S_BRANCH;
                            OP_ADDI:      state_q <= S_ADDIEX;
                            default:      state_q <= S_JUMP;
                        endcase
                    end
                end
                S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (dmem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (dmem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite       = 1'b0;
        branch        = 1'b0;
        irwrite_raw   = 1'b0;
        regwrite_raw  = 1'b0;
        memwrite_raw  = 1'b0;
        dmem_read_raw = 1'b0;
        illegal_raw   = 1'b0;
        alusrca       = 1'b0;
        alusrcb       = SRCB_REG;
        pcsrc         = PCSRC_ALU;
        regdst        = 1'b0;
        memtoreg      = 1'b0;
        alu_class     = AC_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb     = SRCB_INC;
                irwrite_raw = imem_ready;
                pcwrite     = imem_ready;
            end
            S_DECODE: begin
                alusrcb     = SRCB_IMMSH;
                illegal_raw = instr_illegal(op, funct);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: dmem_read_raw = 1'b1;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: memwrite_raw = 1'b1;
            S_EXEC: begin
                alusrca   = 1'b1;
                alu_class = AC_FUNCT;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = 1'b1;
                alu_class = AC_SUB;
                branch    = 1'b1;
                pcsrc     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    mc_aludec u_aludec (
        .alu_class  (alu_class),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign quiet     = reset | reset_q;
    assign pcen      = (pcwrite | (branch & zero)) & ~quiet;
    assign irwrite   = irwrite_raw & ~quiet;
    assign regwrite  = regwrite_raw & ~quiet;
    assign memwrite  = memwrite_raw & ~quiet;
    assign dmem_read = dmem_read_raw & ~quiet;
    assign illegal   = illegal_raw & ~quiet;
    assign state     = state_q;

endmodule
